// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for load-use stalls, taken-branch flushes and trap/MRET redirects
// Ports:
//   h_clk, h_rst            clock, asynchronous active-low reset
//   h_i_id_ce/rs1/rs2       decode-stage valid and source register addresses
//   h_i_ex_ce/load/rd       execute-stage valid, load flag and destination address
//   h_i_branch_taken        execute stage resolved a taken branch/jump
//   h_i_trap, h_i_mret      decode stage holds a trapping instruction or MRET
//   h_o_stall               hold fetch and decode registers
//   h_o_flush_id/ex         squash the decode instruction / bubble the execute stage
//   h_o_redirect(_sel)      load a new PC: 00 branch target, 01 trap vector, 10 mepc
//   h_o_state               current FSM state
// Optional macro HAZARD_PERF_EN adds saturating counters h_o_stall_cnt and h_o_flush_cnt.
module hazard_ctrl #(
    parameter int AWIDTH       = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_id_ce,
    input  logic [AWIDTH-1:0] h_i_id_rs1,
    input  logic [AWIDTH-1:0] h_i_id_rs2,
    input  logic              h_i_ex_ce,
    input  logic              h_i_ex_load,
    input  logic [AWIDTH-1:0] h_i_ex_rd,
    input  logic              h_i_branch_taken,
    input  logic              h_i_trap,
    input  logic              h_i_mret,
    output logic              h_o_stall,
    output logic              h_o_flush_id,
    output logic              h_o_flush_ex,
    output logic              h_o_redirect,
    output logic [1:0]        h_o_redirect_sel,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       h_o_stall_cnt,
    output logic [31:0]       h_o_flush_cnt,
`endif
    output logic [1:0]        h_o_state
);
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        DRAIN      = 2'b10,
        REDIRECT   = 2'b11
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mret_q, mret_d;
    logic       load_use;

    assign load_use = h_i_id_ce && h_i_ex_ce && h_i_ex_load && (h_i_ex_rd != '0) &&
                      ((h_i_ex_rd == h_i_id_rs1) || (h_i_ex_rd == h_i_id_rs2));
    assign h_o_state = state_q;

    // Outputs are gated by reset so nothing is requested while the block is held in reset.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        mret_d           = mret_q;
        h_o_stall        = 1'b0;
        h_o_flush_id     = 1'b0;
        h_o_flush_ex     = 1'b0;
        h_o_redirect     = 1'b0;
        h_o_redirect_sel = 2'b00;
        if (h_rst) begin
            case (state_q)
                RUN: begin
                    if (h_i_branch_taken) begin
                        h_o_redirect = 1'b1;
                        h_o_flush_id = 1'b1;
                        h_o_flush_ex = 1'b1;
                    end else if (h_i_id_ce && (h_i_trap || h_i_mret)) begin
                        h_o_stall    = 1'b1;
                        h_o_flush_ex = 1'b1;
                        mret_d       = !h_i_trap;
                        cnt_d        = DRAIN_LOAD;
                        state_d      = DRAIN;
                    end else if (load_use) begin
                        h_o_stall    = 1'b1;
                        h_o_flush_ex = 1'b1;
                        state_d      = LOAD_STALL;
                    end
                end
                LOAD_STALL: state_d = RUN;
                DRAIN: begin
                    // A taken branch from an older instruction means the trap was on the wrong path.
                    if (h_i_branch_taken) begin
                        h_o_redirect = 1'b1;
                        h_o_flush_id = 1'b1;
                        h_o_flush_ex = 1'b1;
                        mret_d       = 1'b0;
                        cnt_d        = 4'd0;
                        state_d      = RUN;
                    end else begin
                        h_o_stall    = 1'b1;
                        h_o_flush_ex = 1'b1;
                        cnt_d        = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                        state_d      = (cnt_q == 4'd0) ? REDIRECT : DRAIN;
                    end
                end
                default: begin
                    h_o_redirect     = 1'b1;
                    h_o_flush_id     = 1'b1;
                    h_o_flush_ex     = 1'b1;
                    h_o_redirect_sel = mret_q ? 2'b10 : 2'b01;
                    mret_d           = 1'b0;
                    state_d          = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mret_q  <= mret_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    assign h_o_stall_cnt = stall_cnt_q;
    assign h_o_flush_cnt = flush_cnt_q;

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (h_o_stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (h_o_flush_id && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl with DRAIN_CYCLES=3 and DRAIN_CYCLES=1 instances
module tb_hazard_ctrl;
    logic       h_clk = 1'b0;
    logic       h_rst = 1'b0;
    logic       id_ce, ex_ce, ex_load, br, trap, mret;
    logic [4:0] rs1, rs2, ex_rd;
    logic       s0, fi0, fe0, r0, s1, fi1, fe1, r1;
    logic [1:0] sel0, st0, sel1, st1;
`ifdef HAZARD_PERF_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 h_clk = ~h_clk;

    hazard_ctrl #(.AWIDTH(5), .DRAIN_CYCLES(3)) u0 (
        .h_clk(h_clk), .h_rst(h_rst), .h_i_id_ce(id_ce), .h_i_id_rs1(rs1), .h_i_id_rs2(rs2),
        .h_i_ex_ce(ex_ce), .h_i_ex_load(ex_load), .h_i_ex_rd(ex_rd), .h_i_branch_taken(br),
        .h_i_trap(trap), .h_i_mret(mret), .h_o_stall(s0), .h_o_flush_id(fi0), .h_o_flush_ex(fe0),
        .h_o_redirect(r0), .h_o_redirect_sel(sel0),
`ifdef HAZARD_PERF_EN
        .h_o_stall_cnt(sc0), .h_o_flush_cnt(fc0),
`endif
        .h_o_state(st0));

    hazard_ctrl #(.AWIDTH(5), .DRAIN_CYCLES(1)) u1 (
        .h_clk(h_clk), .h_rst(h_rst), .h_i_id_ce(id_ce), .h_i_id_rs1(rs1), .h_i_id_rs2(rs2),
        .h_i_ex_ce(ex_ce), .h_i_ex_load(ex_load), .h_i_ex_rd(ex_rd), .h_i_branch_taken(br),
        .h_i_trap(trap), .h_i_mret(mret), .h_o_stall(s1), .h_o_flush_id(fi1), .h_o_flush_ex(fe1),
        .h_o_redirect(r1), .h_o_redirect_sel(sel1),
`ifdef HAZARD_PERF_EN
        .h_o_stall_cnt(sc1), .h_o_flush_cnt(fc1),
`endif
        .h_o_state(st1));

    // Packed view: {stall, flush_id, flush_ex, redirect, sel[1:0], state[1:0]}
    function automatic logic [7:0] obs(int k);
        return (k == 0) ? {s0, fi0, fe0, r0, sel0, st0} : {s1, fi1, fe1, r1, sel1, st1};
    endfunction

    // Reference model: per instance, count of drain cycles still owed, a pending one-cycle bubble,
    // a pending redirect and the redirect target of the pending trap/MRET.
    int         dlen [2] = '{3, 1};
    int         drain_rem [2];
    bit         bubble [2];
    bit         redir [2];
    logic [1:0] ksel [2];

    function automatic logic is_lu();
        return id_ce && ex_ce && ex_load && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    endfunction

    function automatic logic [7:0] model_out(int k);
        logic [1:0] st;
        if (!h_rst) return 8'h00;
        st = redir[k] ? 2'd3 : (drain_rem[k] > 0) ? 2'd2 : bubble[k] ? 2'd1 : 2'd0;
        if (redir[k]) return {4'b0111, ksel[k], st};
        if (drain_rem[k] > 0) return br ? {6'b011100, st} : {6'b101000, st};
        if (bubble[k]) return {6'b000000, st};
        if (br) return 8'h70;
        if (id_ce && (trap || mret)) return 8'hA0;
        if (is_lu()) return 8'hA0;
        return 8'h00;
    endfunction

    task automatic model_adv(int k);
        if (redir[k]) redir[k] = 1'b0;
        else if (drain_rem[k] > 0) begin
            if (br) drain_rem[k] = 0;
            else begin
                drain_rem[k]--;
                if (drain_rem[k] == 0) redir[k] = 1'b1;
            end
        end else if (bubble[k]) bubble[k] = 1'b0;
        else if (br) ;
        else if (id_ce && (trap || mret)) begin
            drain_rem[k] = dlen[k];
            ksel[k] = trap ? 2'b01 : 2'b10;
        end else if (is_lu()) bubble[k] = 1'b1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            drain_rem[k] = 0;
            bubble[k] = 1'b0;
            redir[k] = 1'b0;
            ksel[k] = 2'b00;
        end
    endtask

    task automatic idle();
        {id_ce, ex_ce, ex_load, br, trap, mret} = '0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        ex_rd = 5'd0;
    endtask

    task automatic rand_inputs();
        id_ce   = ($urandom_range(0, 3) != 0);
        rs1     = 5'($urandom_range(0, 3));
        rs2     = 5'($urandom_range(0, 3));
        ex_ce   = ($urandom_range(0, 3) != 0);
        ex_load = 1'($urandom_range(0, 1));
        ex_rd   = 5'($urandom_range(0, 3));
        br      = ($urandom_range(0, 9) == 0);
        trap    = ($urandom_range(0, 11) == 0);
        mret    = !trap && ($urandom_range(0, 11) == 0);
    endtask

    task automatic test_reset();
        h_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            br = 1'b1;
            id_ce = 1'b1;
            trap = 1'b1;
            #3;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== 8'h00) begin
                    miscompares++;
                    $display("FAIL reset[%0d] u%0d got %h exp 00", i, k, obs(k));
                end
            end
            #7;
        end
`ifdef HAZARD_PERF_EN
        vectors++;
        if ({sc0, fc0, sc1, fc1} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %h %h %h %h exp 0", sc0, fc0, sc1, fc1);
        end
`endif
        idle();
        @(negedge h_clk);
        h_rst = 1'b1;
        model_reset();
        @(posedge h_clk);
        #1;
    endtask

    task automatic test_trap();
        logic [7:0] e0 [6] = '{8'hA0, 8'hA2, 8'hA2, 8'hA2, 8'h77, 8'h00};
        logic [7:0] e1 [6] = '{8'hA0, 8'hA2, 8'h77, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin
                id_ce = 1'b1;
                trap = 1'b1;
            end
            @(negedge h_clk);
            vectors += 2;
            if (obs(0) !== e0[i]) begin
                miscompares++;
                $display("FAIL trap[%0d] u0 got %h exp %h", i, obs(0), e0[i]);
            end
            if (obs(1) !== e1[i]) begin
                miscompares++;
                $display("FAIL trap[%0d] u1 got %h exp %h", i, obs(1), e1[i]);
            end
            @(posedge h_clk);
            #1;
        end
`ifdef HAZARD_PERF_EN
        vectors++;
        if ({sc0, fc0, sc1, fc1} !== {32'd4, 32'd1, 32'd2, 32'd1}) begin
            miscompares++;
            $display("FAIL trap_cnt got %0d %0d %0d %0d exp 4 1 2 1", sc0, fc0, sc1, fc1);
        end
`endif
    endtask

    task automatic test_mret();
        logic [7:0] e0 [6] = '{8'hA0, 8'hA2, 8'hA2, 8'hA2, 8'h7B, 8'h00};
        logic [7:0] e1 [6] = '{8'hA0, 8'hA2, 8'h7B, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin
                id_ce = 1'b1;
                mret = 1'b1;
            end
            @(negedge h_clk);
            vectors += 2;
            if (obs(0) !== e0[i]) begin
                miscompares++;
                $display("FAIL mret[%0d] u0 got %h exp %h", i, obs(0), e0[i]);
            end
            if (obs(1) !== e1[i]) begin
                miscompares++;
                $display("FAIL mret[%0d] u1 got %h exp %h", i, obs(1), e1[i]);
            end
            @(posedge h_clk);
            #1;
        end
    endtask

    task automatic test_drain_abort();
        logic [7:0] e0 [6] = '{8'hA0, 8'hA2, 8'h72, 8'h00, 8'h00, 8'h00};
        logic [7:0] e1 [6] = '{8'hA0, 8'hA2, 8'h77, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin
                id_ce = 1'b1;
                trap = 1'b1;
            end
            if (i == 2) br = 1'b1;
            @(negedge h_clk);
            vectors += 2;
            if (obs(0) !== e0[i]) begin
                miscompares++;
                $display("FAIL drain_abort[%0d] u0 got %h exp %h", i, obs(0), e0[i]);
            end
            if (obs(1) !== e1[i]) begin
                miscompares++;
                $display("FAIL drain_abort[%0d] u1 got %h exp %h", i, obs(1), e1[i]);
            end
            @(posedge h_clk);
            #1;
        end
    endtask

    task automatic test_priority();
        logic [7:0] e [2] = '{8'h70, 8'h00};
        for (int i = 0; i < 2; i++) begin
            idle();
            if (i == 0) begin
                {id_ce, ex_ce, ex_load, br, trap} = 5'b11111;
                rs1 = 5'd5;
                ex_rd = 5'd5;
            end
            @(negedge h_clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== e[i]) begin
                    miscompares++;
                    $display("FAIL priority[%0d] u%0d got %h exp %h", i, k, obs(k), e[i]);
                end
            end
            @(posedge h_clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        logic [7:0] e [7] = '{8'hA0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            idle();
            ex_ce = 1'b1;
            ex_load = 1'b1;
            ex_rd = (i == 3) ? 5'd0 : 5'd5;
            rs1 = (i == 3) ? 5'd0 : 5'd5;
            id_ce = (i == 0) || (i == 3);
            trap = (i == 5);
            mret = (i == 6);
            if (i == 1 || i == 2) {ex_ce, ex_load} = 2'b00;
            @(negedge h_clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== e[i]) begin
                    miscompares++;
                    $display("FAIL load_use[%0d] u%0d got %h exp %h", i, k, obs(k), e[i]);
                end
            end
            @(posedge h_clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        idle();
        id_ce = 1'b1;
        trap = 1'b1;
        @(posedge h_clk);
        #1;
        idle();
        @(negedge h_clk);
        vectors++;
        if (obs(0) !== 8'hA2) begin
            miscompares++;
            $display("FAIL reset_mid_drain u0 got %h exp a2", obs(0));
        end
        @(posedge h_clk);
        #1;
        h_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs(k) !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_mid_hold u%0d got %h exp 00", k, obs(k));
            end
        end
        @(negedge h_clk);
        h_rst = 1'b1;
        model_reset();
        @(posedge h_clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge h_clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== 8'h00) begin
                    miscompares++;
                    $display("FAIL reset_mid_after[%0d] u%0d got %h exp 00", i, k, obs(k));
                end
            end
            @(posedge h_clk);
            #1;
        end
    endtask

    task automatic test_random();
        int es [2] = '{0, 0};
        int ef [2] = '{0, 0};
        logic [7:0] e;
        h_rst = 1'b0;
        idle();
        #3;
        @(negedge h_clk);
        h_rst = 1'b1;
        model_reset();
        @(posedge h_clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            @(negedge h_clk);
            for (int k = 0; k < 2; k++) begin
                e = model_out(k);
                es[k] += int'(e[7]);
                ef[k] += int'(e[6]);
                vectors++;
                if (obs(k) !== e) begin
                    miscompares++;
                    $display("FAIL random[%0d] u%0d got %h exp %h", i, k, obs(k), e);
                end
                model_adv(k);
            end
            @(posedge h_clk);
            #1;
        end
`ifdef HAZARD_PERF_EN
        vectors++;
        if ({sc0, fc0, sc1, fc1} !== {32'(es[0]), 32'(ef[0]), 32'(es[1]), 32'(ef[1])}) begin
            miscompares++;
            $display("FAIL random_cnt got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                     sc0, fc0, sc1, fc1, es[0], ef[0], es[1], ef[1]);
        end
`endif
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_trap();
        test_mret();
        test_drain_abort();
        test_priority();
        test_load_use();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
